lin_frame_deserializer: RTL

//  Serial front end for the 32-channel linear-sample capture stage.
//  - Deserializes a framed, MSB-first serial stream into 21-bit x_lin words.
//  - Each completed word is presented on x_lin together with a one-hot, single-cycle

---
 rtl/lin_frame_deserializer.sv | 108 ++++++++++
 1 files changed

// File: rtl/lin_frame_deserializer.sv
// rtl/lin_frame_deserializer.sv - framed MSB-first serial to 21-bit word deserializer with one-hot channel strobes
module lin_frame_deserializer #(
  parameter int NUM_CH = 32,
  parameter int WIDTH  = 21
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              FrameStart,
  input  logic              InStrobe,
  input  logic              SerIn,
  output logic [NUM_CH-1:0] enable,
  output logic [WIDTH-1:0]  x_lin,
  output logic              FrameDone,
  output logic              FrameErr
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [CH_W-1:0]     r_ch;
  logic [WIDTH-1:0]    r_sreg;
  logic [NUM_CH-1:0]   r_enable;
  logic [WIDTH-1:0]    r_x_lin;
  logic                r_frame_done;
  logic                r_frame_err;

  logic [WIDTH-1:0]    w_shift;
  logic                w_last_bit;
  logic                w_last_ch;
  logic                w_mid_frame;
  logic [NUM_CH-1:0]   w_onehot;
  logic [CNT_W-1:0]    w_restart_cnt;

  assign w_shift       = {r_sreg[WIDTH-2:0], SerIn};
  assign w_last_bit    = (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_last_ch     = (r_ch == CH_W'(NUM_CH - 1));
  assign w_mid_frame   = (r_ch != '0) || (r_bit_cnt != '0);
  assign w_onehot      = {{(NUM_CH-1){1'b0}}, 1'b1} << r_ch;
  // A strobe coincident with FrameStart is the first bit of the new frame.
  assign w_restart_cnt = InStrobe ? CNT_W'(1) : '0;

  // Frame FSM: shifts bits, issues one-hot strobes on word completion, flags aborted frames.
  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_ch         <= '0;
      r_sreg       <= '0;
      r_enable     <= '0;
      r_x_lin      <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_enable     <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (FrameStart) begin
            r_state   <= ST_SHIFT;
            r_ch      <= '0;
            r_bit_cnt <= w_restart_cnt;
            if (InStrobe) r_sreg <= w_shift;
          end
        end
        ST_SHIFT: begin
          if (FrameStart) begin
            // Restart wins over any pending completion; the partial word is dropped.
            r_frame_err <= w_mid_frame;
            r_ch        <= '0;
            r_bit_cnt   <= w_restart_cnt;
            if (InStrobe) r_sreg <= w_shift;
          end else if (InStrobe) begin
            r_sreg <= w_shift;
            if (w_last_bit) begin
              r_x_lin   <= w_shift;
              r_enable  <= w_onehot;
              r_bit_cnt <= '0;
              if (w_last_ch) begin
                r_frame_done <= 1'b1;
                r_ch         <= '0;
                r_state      <= ST_IDLE;
              end else begin
                r_ch <= r_ch + CH_W'(1);
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign enable    = r_enable;
  assign x_lin     = r_x_lin;
  assign FrameDone = r_frame_done;
  assign FrameErr  = r_frame_err;

endmodule
